pipe_load_ctrl: RTL and testbench
=================================

Name: pipe_load_ctrl

Overview:
Load-enable sequencer for a PIPELINE_STAGE-deep register pipeline built from the team's per-stage-enabled pipe register chain. It tracks a valid bit per stage and generates the per-stage load enables. Provides valid/ready handshakes upstream and downstream, collapses bubbles, and supports flush and freeze. It sits beside each data pipe register chain in the decoder datapath and drives that chain's load-enable vector.

Parameters:
PIPELINE_STAGE, 5, number of stages controlled (>=2)
CNT_WIDTH, 3, width of occupancy count; must satisfy 2^CNT_WIDTH > PIPELINE_STAGE

Ports:
sys_clk  input  1  system clock, all logic on rising edge
rst  input  1  synchronous active-high reset
up_valid_i  input  1  upstream data valid at pipe input
up_ready_o  output  1  stage 0 can accept this cycle
down_valid_o  output  1  last stage holds valid data
down_ready_i  input  1  downstream consumes last stage
flush_i  input  1  discard all in-flight entries
freeze_i  input  1  global stall, no movement
pipeLoad_en_o  output  PIPELINE_STAGE  per-stage load enable to the pipe register chain
stage_valid_o  output  PIPELINE_STAGE  per-stage valid bits
occupancy_o  output  CNT_WIDTH  number of valid stages
empty_o  output  1  occupancy == 0
full_o  output  1  occupancy == PIPELINE_STAGE

Behaviour:
- Reset: stage valid bits = 0, occupancy_o = 0, empty_o = 1, full_o = 0. pipeLoad_en_o, up_ready_o and down_valid_o are held at 0 while rst = 1.
- Combinational accept chain:
  - acc[N-1] = !v[N-1] | down_ready_i
  - acc[k] = !v[k] | (v[k] & acc[k+1]) for k < N-1
- Stage 0 load: pipeLoad_en_o[0] = up_valid_i & acc[0]. Stage k>0 load: pipeLoad_en_o[k] = v[k-1] & acc[k].
- up_ready_o = acc[0]; down_valid_o = v[N-1]. All are gated by the freeze/flush rules below.
- Valid update per stage:
  - v[k] <= 1 if pipeLoad_en_o[k].
  - Otherwise v[k] <= 0 if the stage's entry leaves: v[k] & acc[k+1] for k < N-1, or down_ready_i for the last stage.
  - Otherwise v[k] holds.
- Bubble collapse: a stage holding no data is always loadable, even when the last stage is stalled.
- Latency: an empty pipe gives data accepted at cycle t with down_valid_o = 1 at t+N.
- Throughput: one entry per cycle when down_ready_i is held high.
- Data/enable alignment: the pipe register chain loads exactly on pipeLoad_en_o; the controller never asserts an enable for a stage whose source is invalid.
- freeze_i = 1:
  - pipeLoad_en_o = 0, up_ready_o = 0, down_valid_o = 0.
  - All valid bits and occupancy hold.
  - down_ready_i is ignored, so no retirement occurs.
- flush_i = 1:
  - pipeLoad_en_o = 0, up_ready_o = 0, down_valid_o = 0 in that cycle.
  - All valid bits clear next cycle; occupancy_o = 0 next cycle.
  - flush_i has priority over freeze_i.
- Precedence: rst > flush_i > freeze_i > normal operation.
- occupancy_o is registered and updated in the same edge as the valid bits:
  - +1 on input fire (up_valid_i & up_ready_o) without output fire.
  - -1 on output fire (down_valid_o & down_ready_i) without input fire.
  - Unchanged when both or neither fire.
- empty_o and full_o are decoded from the registered occupancy.
- Simultaneous input and output fire while full: allowed, because full_o with down_ready_i = 1 gives up_ready_o = 1. Occupancy stays at PIPELINE_STAGE.
- up_valid_i with up_ready_o = 0: nothing is captured, and upstream holds its data.

Optional Feature:
PIPE_LOAD_CTRL_PERF_EN:
- When defined, adds two outputs:
  - stall_cnt_o (32 bits): counts cycles with up_valid_i = 1 and up_ready_o = 0.
  - retire_cnt_o (32 bits): counts output fires.
- Both counters clear on rst and on flush_i, and saturate at all-ones.
- When undefined, neither the ports nor the logic exist, and the remaining behaviour is identical.

Test Plan:
- Reset, then up_valid_i = 1 for 1 cycle with down_ready_i = 1 -> pipeLoad_en_o walks 00001, 00010, 00100, 01000, 10000; down_valid_o = 1 exactly 5 cycles after the accept; occupancy_o returns to 0.
- Continuous up_valid_i = 1 with down_ready_i = 0 -> after 5 accepts, full_o = 1, up_ready_o = 0, occupancy_o = 5; raise down_ready_i -> one retire and one accept per cycle, occupancy_o stays 5.
- Insert 2 entries 3 cycles apart with down_ready_i = 0 -> entries compact into stages 4 and 3; stage_valid_o = 11000; no enable is issued for an invalid source.
- Pipe with occupancy 3, assert freeze_i for 4 cycles -> pipeLoad_en_o = 0, down_valid_o = 0 and stage_valid_o unchanged; after release, movement resumes from the same state.
- Occupancy 4 with flush_i = 1 and freeze_i = 1 in the same cycle -> next cycle stage_valid_o = 00000, empty_o = 1, up_ready_o = 1 (flush wins).
- With PIPE_LOAD_CTRL_PERF_EN, hold up_valid_i = 1 with the pipe full for 7 cycles -> stall_cnt_o = 7; flush -> both counters read 0.

Source files
------------

// File: rtl/pipe_load_ctrl_if.sv
// Handshake and load-enable bundle between a pipe load controller and its surroundings.
// The perf counter signals exist only when PIPE_LOAD_CTRL_PERF_EN is defined.
interface pipe_load_ctrl_if #(
   parameter int PIPELINE_STAGE = 5,
   parameter int CNT_WIDTH      = 3
);
   logic                      up_valid_i;
   logic                      up_ready_o;
   logic                      down_valid_o;
   logic                      down_ready_i;
   logic                      flush_i;
   logic                      freeze_i;
   logic [PIPELINE_STAGE-1:0] pipeLoad_en_o;
   logic [PIPELINE_STAGE-1:0] stage_valid_o;
   logic [CNT_WIDTH-1:0]      occupancy_o;
   logic                      empty_o;
   logic                      full_o;
`ifdef PIPE_LOAD_CTRL_PERF_EN
   logic [31:0]               stall_cnt_o;
   logic [31:0]               retire_cnt_o;
`endif

   modport master (
      output up_valid_i, down_ready_i, flush_i, freeze_i,
      input  up_ready_o, down_valid_o, pipeLoad_en_o, stage_valid_o,
             occupancy_o, empty_o, full_o
`ifdef PIPE_LOAD_CTRL_PERF_EN
      , input stall_cnt_o, retire_cnt_o
`endif
   );

   modport slave (
      input  up_valid_i, down_ready_i, flush_i, freeze_i,
      output up_ready_o, down_valid_o, pipeLoad_en_o, stage_valid_o,
             occupancy_o, empty_o, full_o
`ifdef PIPE_LOAD_CTRL_PERF_EN
      , output stall_cnt_o, retire_cnt_o
`endif
   );
endinterface

// File: rtl/pipe_load_ctrl.sv
// Valid-tracking load-enable sequencer for a per-stage-enabled pipe register chain, with
// bubble collapse, flush and freeze. Define PIPE_LOAD_CTRL_PERF_EN to add stall/retire counters.
module pipe_load_ctrl #(
   parameter int PIPELINE_STAGE = 5,
   parameter int CNT_WIDTH      = 3
) (
   input  logic            sys_clk,
   input  logic            rst,
   pipe_load_ctrl_if.slave pif
);
   localparam int N = PIPELINE_STAGE;

   logic [N-1:0]         stage_vld;
   logic [N-1:0]         stage_vld_nxt;
   logic [N-1:0]         acc;
   logic [N-1:0]         load_en;
   logic [N-1:0]         leave;
   logic                 active;
   logic                 up_ready;
   logic                 down_valid;
   logic                 in_fire;
   logic                 out_fire;
   logic [CNT_WIDTH-1:0] occ;

   assign active = !rst && !pif.flush_i && !pif.freeze_i;

   // A stage can accept when it, or any stage downstream of it, will free up this cycle.
   always_comb begin : accept_chain
      logic a;
      acc      = '0;
      a        = !stage_vld[N-1] || pif.down_ready_i;
      acc[N-1] = a;
      for (int k = N - 2; k >= 0; k--) begin
         a      = !stage_vld[k] || a;
         acc[k] = a;
      end
   end

   always_comb begin
      load_en = '0;
      leave   = '0;
      if (active) begin
         load_en[0] = pif.up_valid_i && acc[0];
         for (int k = 1; k < N; k++) begin
            load_en[k] = stage_vld[k-1] && acc[k];
         end
         for (int k = 0; k < N - 1; k++) begin
            leave[k] = stage_vld[k] && acc[k+1];
         end
         leave[N-1] = stage_vld[N-1] && pif.down_ready_i;
      end
   end

   assign stage_vld_nxt = load_en | (stage_vld & ~leave);

   assign up_ready   = active && acc[0];
   assign down_valid = active && stage_vld[N-1];
   assign in_fire    = pif.up_valid_i && up_ready;
   assign out_fire   = down_valid && pif.down_ready_i;

   always_ff @(posedge sys_clk) begin
      if (rst || pif.flush_i) begin
         stage_vld <= '0;
         occ       <= '0;
      end else begin
         stage_vld <= stage_vld_nxt;
         if (in_fire && !out_fire) begin
            occ <= occ + CNT_WIDTH'(1);
         end else if (out_fire && !in_fire) begin
            occ <= occ - CNT_WIDTH'(1);
         end
      end
   end

   assign pif.up_ready_o    = up_ready;
   assign pif.down_valid_o  = down_valid;
   assign pif.pipeLoad_en_o = load_en;
   assign pif.stage_valid_o = stage_vld;
   assign pif.occupancy_o   = occ;
   assign pif.empty_o       = (occ == '0);
   assign pif.full_o        = (occ == CNT_WIDTH'(N));

`ifdef PIPE_LOAD_CTRL_PERF_EN
   logic [31:0] stall_cnt;
   logic [31:0] retire_cnt;

   function automatic logic [31:0] sat_inc(input logic [31:0] cnt);
      return (cnt == '1) ? cnt : cnt + 32'd1;
   endfunction

   // Freeze cycles with pending input count as stalls, since upstream is held off.
   always_ff @(posedge sys_clk) begin
      if (rst || pif.flush_i) begin
         stall_cnt  <= '0;
         retire_cnt <= '0;
      end else begin
         if (pif.up_valid_i && !up_ready) begin
            stall_cnt <= sat_inc(stall_cnt);
         end
         if (out_fire) begin
            retire_cnt <= sat_inc(retire_cnt);
         end
      end
   end

   assign pif.stall_cnt_o  = stall_cnt;
   assign pif.retire_cnt_o = retire_cnt;
`endif
endmodule

// File: tb/tb_pipe_load_ctrl.sv
// Scoreboard bench for pipe_load_ctrl: entry-position reference model plus a data chain
// driven by the DUT enables, checked by an independent retire monitor.
module tb_pipe_load_ctrl;
   localparam int N  = 5;
   localparam int CW = 3;

   logic sys_clk = 1'b0;
   logic rst;
   always #5 sys_clk = ~sys_clk;

   pipe_load_ctrl_if #(.PIPELINE_STAGE(N), .CNT_WIDTH(CW)) pif ();

   pipe_load_ctrl #(.PIPELINE_STAGE(N), .CNT_WIDTH(CW)) dut (
      .sys_clk (sys_clk),
      .rst     (rst),
      .pif     (pif.slave)
   );

   int n_checks = 0;
   int n_fail   = 0;

   // Data chain loaded only by the DUT enables; retired words must come out in order.
   logic [15:0] up_data;
   logic [15:0] dchain [N];
   always @(posedge sys_clk) begin
      for (int k = N - 1; k >= 0; k--) begin
         if (pif.pipeLoad_en_o[k]) dchain[k] <= (k == 0) ? up_data : dchain[k-1];
      end
   end

   logic [15:0] sb_q [$];
   int          mpos [$];   // reference model: stage index of each entry, oldest first
   longint      stall_m;
   longint      retire_m;

   task automatic check(input string nm, input logic [63:0] act, input logic [63:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
      end
   endtask

   // Retire monitor: pops the scoreboard whenever the DUT presents an output fire.
   always @(negedge sys_clk) begin
      if (pif.down_valid_o === 1'b1 && pif.down_ready_i === 1'b1) begin
         if (sb_q.size() == 0) begin
            n_checks++;
            n_fail++;
            $display("FAIL retire_unexpected: got retire with empty scoreboard at %0t", $time);
         end else begin
            check("retire_data", dchain[N-1], sb_q.pop_front());
         end
      end
   end

   task automatic step(input logic uv, input logic dr, input logic fl, input logic fz,
                       input logic rs);
      logic         act;
      logic         exp_ur;
      logic         exp_dv;
      logic [N-1:0] sv;
      logic [N-1:0] en;
      int           cnt;
      int           ahead;
      int           np [$];
      @(posedge sys_clk);
      #1;
      rst              = rs;
      pif.up_valid_i   = uv;
      pif.down_ready_i = dr;
      pif.flush_i      = fl;
      pif.freeze_i     = fz;
      up_data          = 16'($urandom);
      #1;
      act    = !rs && !fl && !fz;
      cnt    = mpos.size();
      sv     = '0;
      foreach (mpos[i]) sv[mpos[i]] = 1'b1;
      exp_ur = act && (cnt < N || dr);
      exp_dv = act && cnt > 0 && mpos[0] == N - 1;
      en     = '0;
      ahead  = N;
      if (act) begin
         foreach (mpos[i]) begin
            if (mpos[i] == N - 1) begin
               if (dr) ahead = N;
               else begin np.push_back(N - 1); ahead = N - 1; end
            end else if (mpos[i] + 1 < ahead) begin
               np.push_back(mpos[i] + 1);
               en[mpos[i] + 1] = 1'b1;
               ahead = mpos[i] + 1;
            end else begin
               np.push_back(mpos[i]);
               ahead = mpos[i];
            end
         end
         if (uv && exp_ur) begin
            np.push_back(0);
            en[0] = 1'b1;
         end
      end
      check("stage_valid", pif.stage_valid_o, sv);
      check("occupancy",   pif.occupancy_o, cnt);
      check("empty",       pif.empty_o, cnt == 0);
      check("full",        pif.full_o, cnt == N);
      check("up_ready",    pif.up_ready_o, exp_ur);
      check("down_valid",  pif.down_valid_o, exp_dv);
      check("load_en",     pif.pipeLoad_en_o, en);
`ifdef PIPE_LOAD_CTRL_PERF_EN
      check("stall_cnt",   pif.stall_cnt_o, stall_m);
      check("retire_cnt",  pif.retire_cnt_o, retire_m);
`endif
      if (rs || fl) begin
         mpos     = {};
         sb_q     = {};
         stall_m  = 0;
         retire_m = 0;
      end else begin
         if (!fz) mpos = np;
         if (uv && exp_ur) sb_q.push_back(up_data);
         if (uv && !exp_ur) stall_m++;
         if (exp_dv && dr) retire_m++;
      end
   endtask

   initial begin
      logic [N-1:0] sv_hold;
      rst              = 1'b1;
      pif.up_valid_i   = 1'b0;
      pif.down_ready_i = 1'b0;
      pif.flush_i      = 1'b0;
      pif.freeze_i     = 1'b0;
      up_data          = '0;
      stall_m          = 0;
      retire_m         = 0;
      repeat (2) @(posedge sys_clk);
      step(1, 1, 0, 0, 1);                        // reset state, outputs held low
      // single entry walks through an empty pipe
      step(1, 1, 0, 0, 0);
      repeat (7) step(0, 1, 0, 0, 0);
      // fill against a stalled sink, then stream at full rate
      repeat (8) step(1, 0, 0, 0, 0);
      repeat (6) step(1, 1, 0, 0, 0);
      // bubble collapse of two spaced entries
      step(0, 0, 1, 0, 0);
      step(1, 0, 0, 0, 0);
      repeat (2) step(0, 0, 0, 0, 0);
      step(1, 0, 0, 0, 0);
      repeat (5) step(0, 0, 0, 0, 0);
      check("compact_sv", pif.stage_valid_o, 5'b11000);
      // freeze with three entries
      step(0, 0, 1, 0, 0);
      repeat (3) step(1, 0, 0, 0, 0);
      step(1, 1, 0, 1, 0);
      sv_hold = pif.stage_valid_o;
      repeat (3) step(1, 1, 0, 1, 0);
      check("freeze_hold", pif.stage_valid_o, sv_hold);
      check("freeze_sv", pif.stage_valid_o, 5'b00111);
      repeat (6) step(0, 1, 0, 0, 0);
      // flush beats freeze
      step(0, 0, 1, 0, 0);
      repeat (4) step(1, 0, 0, 0, 0);
      step(1, 1, 1, 1, 0);
      step(0, 0, 0, 0, 0);
      check("flush_sv", pif.stage_valid_o, 5'b00000);
      check("flush_empty", pif.empty_o, 1'b1);
      check("flush_ready", pif.up_ready_o, 1'b1);
      // seven stall cycles against a full pipe
      step(0, 0, 1, 0, 0);
      repeat (12) step(1, 0, 0, 0, 0);
      step(0, 0, 0, 0, 0);
`ifdef PIPE_LOAD_CTRL_PERF_EN
      check("perf_stall7", pif.stall_cnt_o, 32'd7);
`endif
      step(1, 1, 1, 0, 0);
      step(0, 0, 0, 0, 0);
`ifdef PIPE_LOAD_CTRL_PERF_EN
      check("perf_clr_stall", pif.stall_cnt_o, 32'd0);
      check("perf_clr_retire", pif.retire_cnt_o, 32'd0);
`endif
      // randomized traffic
      for (int i = 0; i < 600; i++) begin
         step($urandom_range(0, 9) < 7, $urandom_range(0, 9) < 6, $urandom_range(0, 31) == 0,
              $urandom_range(0, 7) == 0, $urandom_range(0, 99) == 0);
      end
      repeat (10) step(0, 1, 0, 0, 0);
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end
endmodule
